// File: rtl/bus_drive_arbiter_if.sv
// Request/enable bundle between the bus requesters and the '540 output-enable arbiter.
// The master side owns the requests; the slave side (the arbiter) drives grants and enables.
interface bus_drive_arbiter_if #(
    parameter int N_SRC = 4
);
    localparam int OW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    logic [N_SRC-1:0] req;
    logic [N_SRC-1:0] gnt;
    logic [N_SRC-1:0] oe_n;
    logic [OW-1:0]    owner;
    logic             busy;

    modport master (
        output req,
        input  gnt,
        input  oe_n,
        input  owner,
        input  busy
    );

    modport slave (
        input  req,
        output gnt,
        output oe_n,
        output owner,
        output busy
    );
endinterface

// File: rtl/bus_drive_arbiter.sv
// Round-robin owner selection for N_SRC inverting '540 bus buffers.
// Owner changes always pass through DEAD_CYCLES all-off cycles, so the drivers never overlap.
module bus_drive_arbiter #(
    parameter int N_SRC       = 4,
    parameter int DEAD_CYCLES = 2,
    parameter int MAX_HOLD    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bus_drive_arbiter_if.slave   bus
);
    localparam int OW        = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int HOLD_LAST = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;
    localparam int HW        = (HOLD_LAST > 0) ? $clog2(HOLD_LAST + 1) : 1;
    localparam int DW        = $clog2(DEAD_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, GRANT, DEAD} state_t;

    state_t           state;
    logic [OW-1:0]    rr_ptr;
    logic [OW-1:0]    owner;
    logic [N_SRC-1:0] gnt;
    logic             busy;
    logic [HW-1:0]    hcnt;
    logic [DW-1:0]    dcnt;

    logic             found;
    logic [OW-1:0]    win;
    logic [N_SRC-1:0] win_onehot;
    logic             owner_req;
    logic             others_req;
    logic             hold_hit;

    // Search starts just after the last winner and wraps, so the last winner has lowest priority.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int i = 1; i <= N_SRC; i++) begin
            if (!found && bus.req[(int'(rr_ptr) + i) % N_SRC]) begin
                found = 1'b1;
                win   = OW'((int'(rr_ptr) + i) % N_SRC);
            end
        end
    end

    assign win_onehot = {{(N_SRC-1){1'b0}}, 1'b1} << win;
    assign owner_req  = bus.req[owner];
    assign others_req = |(bus.req & ~gnt);
    assign hold_hit   = (MAX_HOLD != 0) && (hcnt == HW'(HOLD_LAST)) && others_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            rr_ptr <= OW'(N_SRC - 1);
            gnt    <= '0;
            owner  <= '0;
            busy   <= 1'b0;
            hcnt   <= '0;
            dcnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state  <= GRANT;
                        gnt    <= win_onehot;
                        owner  <= win;
                        busy   <= 1'b1;
                        rr_ptr <= win;
                        hcnt   <= '0;
                    end
                end
                GRANT: begin
                    if (!owner_req || hold_hit) begin
                        state <= DEAD;
                        gnt   <= '0;
                        busy  <= 1'b0;
                        dcnt  <= DW'(DEAD_CYCLES - 1);
                    end else if (hcnt != HW'(HOLD_LAST)) begin
                        hcnt <= hcnt + HW'(1);
                    end
                end
                DEAD: begin
                    if (dcnt == '0) begin
                        if (found) begin
                            state  <= GRANT;
                            gnt    <= win_onehot;
                            owner  <= win;
                            busy   <= 1'b1;
                            rr_ptr <= win;
                            hcnt   <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        dcnt <= dcnt - DW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt   = gnt;
    assign bus.oe_n  = ~gnt;
    assign bus.owner = owner;
    assign bus.busy  = busy;
endmodule

// File: tb/tb_bus_drive_arbiter.sv
// Directed scenarios for bus_drive_arbiter (N_SRC=4, DEAD_CYCLES=2, MAX_HOLD=8).
// Outputs are sampled on the falling edge; a monitor checks the one-driver invariant every cycle.
module tb_bus_drive_arbiter;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic [3:0] prev_gnt;

    bus_drive_arbiter_if #(.N_SRC(4)) bus ();

    bus_drive_arbiter #(
        .N_SRC(4),
        .DEAD_CYCLES(2),
        .MAX_HOLD(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every cycle: at most one enable, oe_n mirrors gnt, and no direct owner-to-owner hand-over.
    always @(negedge clk) begin
        checks++;
        if ($countones(~bus.oe_n) > 1 || bus.oe_n !== ~bus.gnt) begin
            errors++;
            $display("[TB] FAIL invariant_oe oe_n=%b gnt=%b (need <=1 low and oe_n==~gnt)", bus.oe_n, bus.gnt);
        end
        checks++;
        if (prev_gnt != 4'b0 && bus.gnt != 4'b0 && bus.gnt !== prev_gnt) begin
            errors++;
            $display("[TB] FAIL invariant_gap gnt went %b -> %b without dead time", prev_gnt, bus.gnt);
        end
        prev_gnt = bus.gnt;
    end

    task automatic do_reset();
        rst_n   = 1'b0;
        bus.req = 4'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        bus.req = 4'b1111;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (bus.oe_n !== 4'hF || bus.gnt !== 4'b0 || bus.busy !== 1'b0 || bus.owner !== 2'd0) begin
                errors++;
                $display("[TB] FAIL reset_state oe_n=%b gnt=%b busy=%b owner=%0d need 1111/0000/0/0",
                         bus.oe_n, bus.gnt, bus.busy, bus.owner);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.gnt !== 4'b0001 || bus.oe_n !== 4'b1110 || bus.busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_first_grant gnt=%b oe_n=%b busy=%b need 0001/1110/1",
                     bus.gnt, bus.oe_n, bus.busy);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.oe_n !== 4'hF || bus.gnt !== 4'b0) begin
            errors++;
            $display("[TB] FAIL reset_async oe_n=%b gnt=%b need 1111/0000", bus.oe_n, bus.gnt);
        end
        bus.req = 4'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_release();
        do_reset();
        bus.req = 4'b0001;
        @(negedge clk);
        checks++;
        if (bus.gnt !== 4'b0001 || bus.owner !== 2'd0 || bus.busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_grant gnt=%b owner=%0d busy=%b need 0001/0/1",
                     bus.gnt, bus.owner, bus.busy);
        end
        bus.req = 4'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (bus.oe_n !== 4'hF || bus.busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL single_release cyc=%0d oe_n=%b busy=%b need 1111/0", c, bus.oe_n, bus.busy);
            end
        end
        bus.req = 4'b0010;
        @(negedge clk);
        checks++;
        if (bus.gnt !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL idle_regrant gnt=%b need 0010", bus.gnt);
        end
        bus.req = 4'b0;
    endtask

    task automatic test_round_robin();
        logic [1:0] order [5];
        order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                checks++;
                if (bus.gnt !== (4'b0001 << order[k]) || bus.owner !== order[k]) begin
                    errors++;
                    $display("[TB] FAIL rr_grant turn=%0d cyc=%0d gnt=%b owner=%0d need owner %0d",
                             k, c, bus.gnt, bus.owner, order[k]);
                end
            end
            bus.req[order[k]] = 1'b0;
            for (int c = 0; c < 2; c++) begin
                @(negedge clk);
                checks++;
                if (bus.gnt !== 4'b0 || bus.oe_n !== 4'hF) begin
                    errors++;
                    $display("[TB] FAIL rr_dead turn=%0d cyc=%0d gnt=%b need 0000", k, c, bus.gnt);
                end
                bus.req = 4'b1111;
            end
        end
        bus.req = 4'b0;
    endtask

    task automatic test_hold_limit();
        do_reset();
        bus.req = 4'b0001;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checks++;
            if (bus.gnt !== 4'b0001) begin
                errors++;
                $display("[TB] FAIL hold_src0 cyc=%0d gnt=%b need 0001", c, bus.gnt);
            end
            bus.req = 4'b0101;
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if (bus.gnt !== 4'b0) begin
                errors++;
                $display("[TB] FAIL hold_dead cyc=%0d gnt=%b need 0000", c, bus.gnt);
            end
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if (bus.gnt !== 4'b0100 || bus.owner !== 2'd2) begin
                errors++;
                $display("[TB] FAIL hold_src2 cyc=%0d gnt=%b owner=%0d need 0100/2", c, bus.gnt, bus.owner);
            end
        end
        bus.req = 4'b0001;
        repeat (2) @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.gnt !== 4'b0001 || bus.owner !== 2'd0 || bus.busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL hold_back_to_src0 gnt=%b owner=%0d busy=%b need 0001/0/1",
                     bus.gnt, bus.owner, bus.busy);
        end
        bus.req = 4'b0;
    endtask

    task automatic test_no_competitor();
        do_reset();
        bus.req = 4'b0010;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++;
            if (bus.gnt !== 4'b0010 || bus.owner !== 2'd1) begin
                errors++;
                $display("[TB] FAIL solo_hold cyc=%0d gnt=%b owner=%0d need 0010/1", c, bus.gnt, bus.owner);
            end
        end
        bus.req = 4'b0;
    endtask

    task automatic test_dead_pulse_lost();
        do_reset();
        bus.req = 4'b0001;
        @(negedge clk);
        checks++;
        if (bus.gnt !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL pulse_grant gnt=%b need 0001", bus.gnt);
        end
        bus.req = 4'b0;
        @(negedge clk);
        bus.req = 4'b1000;
        @(negedge clk);
        bus.req = 4'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (bus.gnt !== 4'b0 || bus.busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL pulse_lost cyc=%0d gnt=%b busy=%b need 0000/0", c, bus.gnt, bus.busy);
            end
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        prev_gnt = 4'b0;
        rst_n    = 1'b0;
        bus.req  = 4'b0;
        test_reset();
        test_single_release();
        test_round_robin();
        test_hold_limit();
        test_no_competitor();
        test_dead_pulse_lost();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
